datapath_ctrl: RTL
==================

# datapath_ctrl

Multicycle controller that sequences the 16-bit datapath (8×16 register file, A/B/C registers, shifter, ALU, Z status) to execute one 16-bit instruction per start request. It latches an instruction, steps the datapath load/select/write strobes through a fixed Moore state machine, and signals completion. It sits between the instruction source (bench, later the fetch unit) and the datapath, and drives every datapath control input.

## Interface
Parameters:
- `W`, 16, datapath word width; the immediate is sign-extended to `W`.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `instr` in 16: instruction, captured on the accepting edge.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse in DONE.
- `err` out 1: valid with `done`; 1 = illegal opcode.
- `readnum`, `writenum` out 3: register-file ports.
- `write`, `vsel`, `loada`, `loadb`, `asel`, `bsel`, `loadc`, `loads` out 1: datapath strobes.
- `shift` out 2, `ALUop` out 2: shifter and ALU select.
- `datapath_in` out W: sign-extended imm8.

## Operation
- Instruction fields: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0].
- Legal encodings:
  - 110/10 MOV Rn,#imm8.
  - 110/00 MOV Rd,Rm{,sh}.
  - 101/00 ADD Rd,Rn,Rm{,sh}.
  - 101/01 CMP Rn,Rm{,sh}.
  - 101/10 AND Rd,Rn,Rm{,sh}.
  - 101/11 MVN Rd,Rm{,sh}.
  - Anything else is illegal.
- States: IDLE, WIMM, LOADA, LOADB, EXEC, WB, DONE.
- Transitions:
  - IDLE: if `start`, latch `instr`. MOV-imm goes to WIMM. ADD/CMP/AND go to LOADA. MOV-reg/MVN go to LOADB. Illegal goes to DONE with `err`=1.
  - WIMM → DONE.
  - LOADA → LOADB.
  - LOADB → EXEC.
  - EXEC → DONE for CMP; otherwise → WB.
  - WB → DONE.
  - DONE → IDLE.
- Outputs are Moore, decoded from state plus the latched instruction. Unlisted strobes are 0.
  - WIMM: `write`=1, `vsel`=1, `writenum`=Rn, `datapath_in`=sxt(imm8).
  - LOADA: `readnum`=Rn, `loada`=1.
  - LOADB: `readnum`=Rm, `loadb`=1.
  - EXEC: `shift`=sh, `bsel`=0, `loadc`=1.
    - `asel`=1 for MOV-reg/MVN, else 0.
    - `ALUop`=00 for MOV-reg, else op.
    - `loads`=1 only for CMP.
  - WB: `write`=1, `vsel`=0, `writenum`=Rd.
- `readnum`/`writenum` hold their last-driven value outside their states. Strobes gate all effects.
- `start` in any non-IDLE state is ignored, not queued.
- Reset, asynchronous at any time:
  - State → IDLE; all outputs 0; latched instruction cleared.
  - An in-flight write is abandoned: no `write` pulse after reset.

## Timing
- Accept on edge E0 (IDLE, `start`=1). The next state is active from E0 to E1.
- `done` latency after accept:
  - MOV-imm: done in cycle 2.
  - MOV-reg/MVN: cycle 4.
  - CMP: cycle 4.
  - ADD/AND: cycle 5.
  - Illegal: cycle 1.
- Back-to-back: `start` held high during DONE is not sampled. A new instruction is accepted at the earliest on the edge after DONE, in IDLE. Minimum gap is 1 idle cycle.
- `busy` rises the cycle after accept and falls with the exit from DONE.

## Configuration
- `DATAPATH_CTRL_PERF_EN` defined:
  - Adds output `instr_count` (16 bits), reset 0.
  - Increments on each DONE with `err`=0; wraps 0xFFFF → 0x0000.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

## Structure
- Package `datapath_ctrl_pkg` holds:
  - the state enum;
  - opcode constants (OPC_MOV=110, OPC_ALU=101);
  - op/ALUop constants (ADD=00, CMP=01, AND=10, MVN=11);
  - shift constants (NONE=00, LSL=01, LSR=10, ASR=11).
- One sub-module `datapath_ctrl_decode`: combinational field split, sign extension, legal/illegal classification, and first-state select.

## Test plan
- MOV R0,#7 (0xD007): one cycle with `write`=1, `vsel`=1, `writenum`=0, `datapath_in`=0x0007; `done` in cycle 2; datapath R0=7.
- MOV R3,#-16 (0xD3F0): `datapath_in`=0xFFF0; R3=0xFFF0.
- With R0=7, R1=2, ADD R2,R1,R0,LSL#1 (0xA148): LOADA readnum=1, LOADB readnum=0, EXEC shift=01 ALUop=00, WB writenum=2; `done` in cycle 5; R2=16.
- With R1=2, R0=2, CMP R1,R0 (0xA900): `loads`=1 only in EXEC; no `write`; Z=1; `done` in cycle 4.
- Reset mid-op: `reset_n` low during LOADB of an ADD. All outputs 0 immediately, `busy`=0, no later `write`, Rd unchanged. The next `start` executes normally.
- Illegal opcode 0xE000: `done`=1 and `err`=1 in cycle 1; no strobes. A `start` during `busy` is ignored, and the latched instruction is unchanged.

Source files
------------

// File: rtl/datapath_ctrl_pkg.sv
// Shared types and encodings for the datapath_ctrl sequencer.
package datapath_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WIMM  = 3'd1,
        S_LOADA = 3'd2,
        S_LOADB = 3'd3,
        S_EXEC  = 3'd4,
        S_WB    = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // op field under OPC_MOV
    localparam logic [1:0] MOV_REG = 2'b00;
    localparam logic [1:0] MOV_IMM = 2'b10;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_CMP = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MVN = 2'b11;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

endpackage

// File: rtl/datapath_ctrl_decode.sv
// Combinational instruction decode: field split, imm8 sign extension,
// legality check and the first state after accept.
module datapath_ctrl_decode
    import datapath_ctrl_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [15:0]  instr_i,
    output logic [1:0]   op_o,
    output logic [2:0]   rn_o,
    output logic [2:0]   rd_o,
    output logic [1:0]   sh_o,
    output logic [2:0]   rm_o,
    output logic [W-1:0] imm_sx_o,
    output logic         legal_o,
    output logic         is_mov_reg_o,
    output logic         is_mvn_o,
    output logic         is_cmp_o,
    output state_t       first_state_o
);

    logic [2:0] opcode;
    logic       is_mov;
    logic       is_alu;
    logic       is_mov_imm;

    assign opcode   = instr_i[15:13];
    assign op_o     = instr_i[12:11];
    assign rn_o     = instr_i[10:8];
    assign rd_o     = instr_i[7:5];
    assign sh_o     = instr_i[4:3];
    assign rm_o     = instr_i[2:0];
    assign imm_sx_o = {{(W-8){instr_i[7]}}, instr_i[7:0]};

    assign is_mov       = (opcode == OPC_MOV);
    assign is_alu       = (opcode == OPC_ALU);
    assign is_mov_imm   = is_mov && (op_o == MOV_IMM);
    assign is_mov_reg_o = is_mov && (op_o == MOV_REG);
    assign is_mvn_o     = is_alu && (op_o == OP_MVN);
    assign is_cmp_o     = is_alu && (op_o == OP_CMP);
    assign legal_o      = is_mov_imm || is_mov_reg_o || is_alu;

    always_comb begin
        if (!legal_o)
            first_state_o = S_DONE;
        else if (is_mov_imm)
            first_state_o = S_WIMM;
        else if (is_mov_reg_o || is_mvn_o)
            first_state_o = S_LOADB;
        else
            first_state_o = S_LOADA;
    end

endmodule

// File: rtl/datapath_ctrl.sv
// Multicycle Moore sequencer driving the 16-bit datapath strobes.
// Optional DATAPATH_CTRL_PERF_EN adds a completed-instruction counter.
module datapath_ctrl
    import datapath_ctrl_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [15:0]  instr,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [2:0]   readnum,
    output logic [2:0]   writenum,
    output logic         write,
    output logic         vsel,
    output logic         loada,
    output logic         loadb,
    output logic         asel,
    output logic         bsel,
    output logic         loadc,
    output logic         loads,
    output logic [1:0]   shift,
    output logic [1:0]   ALUop,
`ifdef DATAPATH_CTRL_PERF_EN
    output logic [15:0]  instr_count,
`endif
    output logic [W-1:0] datapath_in
);

    state_t      state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic        err_q, err_d;
    logic [2:0]  readnum_q;
    logic [2:0]  writenum_q;

    logic [15:0]  dec_instr;
    logic [1:0]   f_op;
    logic [2:0]   f_rn, f_rd, f_rm;
    logic [1:0]   f_sh;
    logic [W-1:0] f_imm;
    logic         f_legal, f_mov_reg, f_mvn, f_cmp;
    state_t       f_first;

    // In IDLE the decoder classifies the incoming word; elsewhere the latched one.
    assign dec_instr = (state_q == S_IDLE) ? instr : instr_q;

    datapath_ctrl_decode #(.W(W)) u_decode (
        .instr_i       (dec_instr),
        .op_o          (f_op),
        .rn_o          (f_rn),
        .rd_o          (f_rd),
        .sh_o          (f_sh),
        .rm_o          (f_rm),
        .imm_sx_o      (f_imm),
        .legal_o       (f_legal),
        .is_mov_reg_o  (f_mov_reg),
        .is_mvn_o      (f_mvn),
        .is_cmp_o      (f_cmp),
        .first_state_o (f_first)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            instr_q    <= '0;
            err_q      <= 1'b0;
            readnum_q  <= '0;
            writenum_q <= '0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            err_q      <= err_d;
            readnum_q  <= readnum;
            writenum_q <= writenum;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    instr_d = instr;
                    err_d   = !f_legal;
                    state_d = f_first;
                end
            end
            S_WIMM:  state_d = S_DONE;
            S_LOADA: state_d = S_LOADB;
            S_LOADB: state_d = S_EXEC;
            S_EXEC:  state_d = f_cmp ? S_DONE : S_WB;
            S_WB:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = 1'b0;
        err         = 1'b0;
        readnum     = readnum_q;
        writenum    = writenum_q;
        write       = 1'b0;
        vsel        = 1'b0;
        loada       = 1'b0;
        loadb       = 1'b0;
        asel        = 1'b0;
        bsel        = 1'b0;
        loadc       = 1'b0;
        loads       = 1'b0;
        shift       = SH_NONE;
        ALUop       = OP_ADD;
        datapath_in = '0;
        case (state_q)
            S_WIMM: begin
                write       = 1'b1;
                vsel        = 1'b1;
                writenum    = f_rn;
                datapath_in = f_imm;
            end
            S_LOADA: begin
                readnum = f_rn;
                loada   = 1'b1;
            end
            S_LOADB: begin
                readnum = f_rm;
                loadb   = 1'b1;
            end
            S_EXEC: begin
                shift = f_sh;
                loadc = 1'b1;
                asel  = f_mov_reg || f_mvn;
                ALUop = f_mov_reg ? OP_ADD : f_op;
                loads = f_cmp;
            end
            S_WB: begin
                write    = 1'b1;
                writenum = f_rd;
            end
            S_DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

`ifdef DATAPATH_CTRL_PERF_EN
    logic [15:0] count_q, count_d;

    assign count_d     = (state_q == S_DONE && !err_q) ? count_q + 16'd1 : count_q;
    assign instr_count = count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end
`endif

endmodule
